// File: rtl/vld_txn_sequencer.sv
// vld_txn_sequencer: splits one unit-stride vector load (nibble address + nibble length) into AXI
// AR bursts that never cross a 4KB page and never exceed MaxBurstLen beats. One descriptor per
// burst is queued and replayed beat by beat as transaction control for the sequential load unit.
module vld_txn_sequencer #(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned MaxBurstLen  = 16,
    parameter int unsigned TxnQDepth    = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [AxiAddrWidth:0]               req_addr_i,
    input  logic [31:0]                         req_len_nb_i,
    output logic                                ar_valid_o,
    input  logic                                ar_ready_i,
    output logic [AxiAddrWidth-1:0]             ar_addr_o,
    output logic [7:0]                          ar_len_o,
    output logic [2:0]                          ar_size_o,
    output logic                                txn_valid_o,
    input  logic                                txn_ready_i,
    output logic [AxiAddrWidth:0]               txn_addr_o,
    output logic                                txn_is_head_o,
    output logic                                txn_is_final_txn_o,
    output logic [7:0]                          txn_rmn_beat_o,
    output logic [$clog2(AxiDataWidth/4):0]     txn_lbn_o,
    output logic                                busy_o
);

    localparam int unsigned BusNibbles = AxiDataWidth / 4;
    localparam int unsigned BusNSize   = $clog2(BusNibbles);
    localparam int unsigned AW         = AxiAddrWidth + 1;
    // Wide enough for offset + 32-bit length and all beat arithmetic without overflow.
    localparam int unsigned CW         = 40;
    localparam int unsigned PageBeats  = 8192 / BusNibbles;
    localparam int unsigned PtrW       = (TxnQDepth > 1) ? $clog2(TxnQDepth) : 1;
    localparam int unsigned CntW       = $clog2(TxnQDepth + 1);
    localparam logic [BusNSize:0] LbnFull = (BusNSize + 1)'(BusNibbles);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic              head;
        logic              final_txn;
        logic [7:0]        len;
        logic [BusNSize:0] lbn;
    } desc_t;

    state_e            r_state;
    logic [AW-1:0]     r_cur_addr;
    logic [32:0]       r_rem_nb;
    logic              r_first;

    desc_t             r_q [TxnQDepth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;
    logic [7:0]        r_beat_cnt;

    logic [CW-1:0]     w_off;
    logic [CW-1:0]     w_span;
    logic [CW-1:0]     w_beats_rem;
    logic [CW-1:0]     w_beats_4k;
    logic [CW-1:0]     w_beats;
    logic [CW-1:0]     w_beats_nb;
    logic              w_final;
    logic [AW-1:0]     w_aligned;
    logic [AW-1:0]     w_next_addr;
    logic [BusNSize:0] w_lbn_raw;
    logic [BusNSize:0] w_lbn;
    logic              w_q_full;
    logic              w_q_empty;
    logic              w_push;
    logic              w_pop;
    desc_t             w_head;
    desc_t             w_new;
    logic [7:0]        w_rmn;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(TxnQDepth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Size the next burst: min of the burst cap, the 4KB page remainder and the request remainder
    always_comb begin
        w_off       = CW'(r_cur_addr[BusNSize-1:0]);
        w_span      = w_off + CW'(r_rem_nb);
        w_beats_rem = (w_span + CW'(BusNibbles - 1)) >> BusNSize;
        w_beats_4k  = CW'(PageBeats) - CW'(r_cur_addr[12:BusNSize]);
        w_beats     = CW'(MaxBurstLen);
        if (w_beats_4k < w_beats) begin
            w_beats = w_beats_4k;
        end
        if (w_beats_rem < w_beats) begin
            w_beats = w_beats_rem;
        end
        w_final     = (w_beats == w_beats_rem);
        w_beats_nb  = w_beats << BusNSize;
        w_aligned   = {r_cur_addr[AW-1:BusNSize], {BusNSize{1'b0}}};
        w_next_addr = w_aligned + AW'(w_beats_nb);
        w_lbn_raw   = (BusNSize + 1)'(w_span - ((w_beats - CW'(1)) << BusNSize));
        w_lbn       = w_final ? w_lbn_raw : LbnFull;
    end

    // AR channel and request handshake; AR fields are zero whenever AR is not valid
    always_comb begin
        req_ready_o = (r_state == StIdle);
        ar_valid_o  = (r_state == StIssue) && !w_q_full;
        ar_size_o   = 3'($clog2(AxiDataWidth / 8));
        ar_addr_o   = '0;
        ar_len_o    = '0;
        if (ar_valid_o) begin
            ar_addr_o = w_aligned[AW-1:1];
            ar_len_o  = w_beats[7:0] - 8'd1;
        end
    end

    // Queue status, push/pop decisions and the descriptor being enqueued
    always_comb begin
        w_q_full  = (r_count == CntW'(TxnQDepth));
        w_q_empty = (r_count == '0);
        w_head    = r_q[r_rptr];
        w_rmn     = w_head.len - r_beat_cnt;
        w_push    = ar_valid_o && ar_ready_i;
        w_pop     = !w_q_empty && txn_ready_i && (w_rmn == 8'd0);
        w_new     = '{addr: r_cur_addr, head: r_first, final_txn: w_final,
                      len: ar_len_o, lbn: w_lbn};
    end

    // Per-beat transaction control from the head descriptor; zero while the queue is empty
    always_comb begin
        txn_valid_o        = !w_q_empty;
        txn_addr_o         = '0;
        txn_is_head_o      = 1'b0;
        txn_is_final_txn_o = 1'b0;
        txn_rmn_beat_o     = '0;
        txn_lbn_o          = '0;
        if (txn_valid_o) begin
            txn_addr_o         = w_head.addr;
            txn_is_head_o      = w_head.head && (r_beat_cnt == 8'd0);
            txn_is_final_txn_o = w_head.final_txn;
            txn_rmn_beat_o     = w_rmn;
            txn_lbn_o          = w_head.lbn;
        end
        busy_o = (r_state != StIdle) || !w_q_empty;
    end

    // Request FSM: latch a request in IDLE, then walk it one burst per AR handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_cur_addr <= '0;
            r_rem_nb   <= '0;
            r_first    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // Zero-length requests are accepted and dropped
                    if (req_valid_i && (req_len_nb_i != 32'd0)) begin
                        r_cur_addr <= req_addr_i;
                        r_rem_nb   <= {1'b0, req_len_nb_i};
                        r_first    <= 1'b1;
                        r_state    <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_push) begin
                        r_first    <= 1'b0;
                        r_cur_addr <= w_next_addr;
                        if (w_final) begin
                            r_rem_nb <= '0;
                            r_state  <= StIdle;
                        end else begin
                            r_rem_nb <= 33'(CW'(r_rem_nb) + w_off - w_beats_nb);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Descriptor FIFO plus the consumed-beat counter of the head entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            for (int i = 0; i < TxnQDepth; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_q[r_wptr] <= w_new;
                r_wptr      <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr     <= ptr_inc(r_rptr);
                r_beat_cnt <= '0;
            end else if (!w_q_empty && txn_ready_i) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vld_txn_sequencer.sv
// Self-checking bench for vld_txn_sequencer: directed vector table, multi-cycle corner sequences
// and randomized requests checked against a page/boundary-based burst model.
module tb_vld_txn_sequencer;

    localparam int unsigned BusNb = 32;
    localparam int unsigned MaxB  = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [64:0] req_addr_i;
    logic [31:0] req_len_nb_i;
    logic        ar_valid_o;
    logic        ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic        txn_valid_o;
    logic        txn_ready_i;
    logic [64:0] txn_addr_o;
    logic        txn_is_head_o;
    logic        txn_is_final_txn_o;
    logic [7:0]  txn_rmn_beat_o;
    logic [5:0]  txn_lbn_o;
    logic        busy_o;

    vld_txn_sequencer #(
        .AxiDataWidth(128),
        .AxiAddrWidth(64),
        .MaxBurstLen (16),
        .TxnQDepth   (4)
    ) u_dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_len_nb_i      (req_len_nb_i),
        .ar_valid_o        (ar_valid_o),
        .ar_ready_i        (ar_ready_i),
        .ar_addr_o         (ar_addr_o),
        .ar_len_o          (ar_len_o),
        .ar_size_o         (ar_size_o),
        .txn_valid_o       (txn_valid_o),
        .txn_ready_i       (txn_ready_i),
        .txn_addr_o        (txn_addr_o),
        .txn_is_head_o     (txn_is_head_o),
        .txn_is_final_txn_o(txn_is_final_txn_o),
        .txn_rmn_beat_o    (txn_rmn_beat_o),
        .txn_lbn_o         (txn_lbn_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        longint unsigned addr;
        int unsigned     len;
        int unsigned     size;
    } ar_t;

    typedef struct {
        longint unsigned addr;
        bit              head;
        bit              fin;
        int unsigned     rmn;
        int unsigned     lbn;
    } beat_t;

    typedef struct {
        string           name;
        longint unsigned addr;
        int unsigned     len;
        int unsigned     n_ar;
        longint unsigned ar0_addr;
        int unsigned     ar0_len;
        longint unsigned arl_addr;
        int unsigned     arl_len;
        longint unsigned beat0_addr;
        int unsigned     last_lbn;
    } vec_t;

    ar_t   obs_ar[$];
    ar_t   exp_ar[$];
    beat_t obs_beat[$];
    beat_t exp_beat[$];

    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;
    bit              req_pending = 0;
    longint unsigned p_addr = 0;
    int unsigned     p_len  = 0;
    bit              hold_ar = 0;
    logic [63:0]     held_addr;
    logic [7:0]      held_len;

    vec_t vecs [5];

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_all();
        obs_ar.delete();
        exp_ar.delete();
        obs_beat.delete();
        exp_beat.delete();
    endtask

    // Burst list derived from boundaries: each burst ends at the earliest of the 16-beat cap,
    // the next 4KB page, or the end of the request rounded up to a bus word.
    function automatic void build_model(input longint unsigned addr, input longint unsigned len);
        longint unsigned pos, endp, eround, al, page, bend, beats;
        bit first, fin;
        pos    = addr;
        endp   = addr + len;
        eround = ((endp + BusNb - 1) / BusNb) * BusNb;
        first  = 1'b1;
        do begin
            al    = pos & ~64'd31;
            page  = (al & ~64'd8191) + 64'd8192;
            bend  = al + MaxB * BusNb;
            if (page < bend) bend = page;
            if (eround < bend) bend = eround;
            beats = (bend - al) / BusNb;
            fin   = (bend == eround);
            exp_ar.push_back('{addr: al >> 1, len: 32'(beats - 1), size: 4});
            for (int i = 0; i < int'(beats); i++) begin
                exp_beat.push_back('{addr: pos, head: first && (i == 0), fin: fin,
                                     rmn: 32'(beats - 1 - longint'(i)),
                                     lbn: fin ? 32'(endp - (al + (beats - 1) * BusNb)) : BusNb});
            end
            pos   = bend;
            first = 1'b0;
        end while (!fin);
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, handshakes commit at the next rise
    task automatic step(input bit arr, input bit txr);
        @(negedge clk_i);
        req_valid_i = req_pending;
        if (req_pending) begin
            req_addr_i   = {1'b0, p_addr};
            req_len_nb_i = p_len;
        end
        ar_ready_i  = arr;
        txn_ready_i = txr;
        #1;
        if (hold_ar) begin
            check("ar_hold_valid", 64'(ar_valid_o), 1);
            check("ar_hold_addr", ar_addr_o, held_addr);
            check("ar_hold_len", 64'(ar_len_o), 64'(held_len));
        end
        hold_ar   = ar_valid_o && !ar_ready_i;
        held_addr = ar_addr_o;
        held_len  = ar_len_o;
        if (ar_valid_o && ar_ready_i) begin
            obs_ar.push_back('{addr: ar_addr_o, len: 32'(ar_len_o), size: 32'(ar_size_o)});
        end
        if (txn_valid_o && txn_ready_i) begin
            obs_beat.push_back('{addr: txn_addr_o[63:0], head: txn_is_head_o,
                                 fin: txn_is_final_txn_o, rmn: 32'(txn_rmn_beat_o),
                                 lbn: 32'(txn_lbn_o)});
        end
        if (req_pending && req_ready_o) begin
            req_pending = 1'b0;
        end
    endtask

    task automatic compare_model(input string tag);
        int unsigned n;
        check($sformatf("%s.n_ar", tag), obs_ar.size(), exp_ar.size());
        check($sformatf("%s.n_beat", tag), obs_beat.size(), exp_beat.size());
        n = (obs_ar.size() < exp_ar.size()) ? obs_ar.size() : exp_ar.size();
        for (int i = 0; i < int'(n); i++) begin
            check($sformatf("%s.ar[%0d].addr", tag, i), obs_ar[i].addr, exp_ar[i].addr);
            check($sformatf("%s.ar[%0d].len", tag, i), obs_ar[i].len, exp_ar[i].len);
            check($sformatf("%s.ar[%0d].size", tag, i), obs_ar[i].size, exp_ar[i].size);
        end
        n = (obs_beat.size() < exp_beat.size()) ? obs_beat.size() : exp_beat.size();
        for (int i = 0; i < int'(n); i++) begin
            check($sformatf("%s.beat[%0d].addr", tag, i), obs_beat[i].addr, exp_beat[i].addr);
            check($sformatf("%s.beat[%0d].head", tag, i), obs_beat[i].head, exp_beat[i].head);
            check($sformatf("%s.beat[%0d].final", tag, i), obs_beat[i].fin, exp_beat[i].fin);
            check($sformatf("%s.beat[%0d].rmn", tag, i), obs_beat[i].rmn, exp_beat[i].rmn);
            check($sformatf("%s.beat[%0d].lbn", tag, i), obs_beat[i].lbn, exp_beat[i].lbn);
        end
    endtask

    task automatic drain(input int unsigned arr_pct, input int unsigned txr_pct,
                         input string tag);
        int unsigned cyc;
        cyc = 0;
        while (!(obs_ar.size() >= exp_ar.size() && obs_beat.size() >= exp_beat.size() &&
                 !busy_o && !req_pending)) begin
            if (cyc >= 4000) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s.timeout: got %0d ARs %0d beats, expected %0d ARs %0d beats",
                         tag, obs_ar.size(), obs_beat.size(), exp_ar.size(), exp_beat.size());
                break;
            end
            step($urandom_range(0, 99) < arr_pct, $urandom_range(0, 99) < txr_pct);
            cyc++;
        end
        repeat (2) step(1'b1, 1'b1);
        compare_model(tag);
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_len_nb_i = '0;
        ar_ready_i   = 1'b0;
        txn_ready_i  = 1'b0;

        vecs[0] = '{"aligned",   64'h0,    64,  1, 64'h0,   1,  64'h0,    1, 64'h0,    32};
        vecs[1] = '{"misalign",  64'h5,    40,  1, 64'h0,   1,  64'h0,    1, 64'h5,    13};
        vecs[2] = '{"cross4k",   64'h1FC0, 128, 2, 64'hFE0, 1,  64'h1000, 1, 64'h1FC0, 32};
        vecs[3] = '{"cap",       64'h0,    640, 2, 64'h0,   15, 64'h100,  3, 64'h0,    32};
        vecs[4] = '{"edge4k",    64'h1FFF, 2,   2, 64'hFF0, 0,  64'h1000, 0, 64'h1FFF, 1};

        // Reset state
        #1;
        check("rst.req_ready", 64'(req_ready_o), 1);
        check("rst.ar_valid", 64'(ar_valid_o), 0);
        check("rst.txn_valid", 64'(txn_valid_o), 0);
        check("rst.busy", 64'(busy_o), 0);
        check("rst.ar_len", 64'(ar_len_o), 0);
        check("rst.txn_lbn", 64'(txn_lbn_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed vectors
        for (int t = 0; t < 5; t++) begin
            clear_all();
            build_model(vecs[t].addr, 64'(vecs[t].len));
            p_addr      = vecs[t].addr;
            p_len       = vecs[t].len;
            req_pending = 1'b1;
            drain(100, 100, vecs[t].name);
            check($sformatf("%s.tbl_n_ar", vecs[t].name), obs_ar.size(), vecs[t].n_ar);
            if (obs_ar.size() == vecs[t].n_ar && obs_beat.size() > 0) begin
                check($sformatf("%s.tbl_ar0_addr", vecs[t].name), obs_ar[0].addr,
                      vecs[t].ar0_addr);
                check($sformatf("%s.tbl_ar0_len", vecs[t].name), obs_ar[0].len,
                      vecs[t].ar0_len);
                check($sformatf("%s.tbl_size", vecs[t].name), obs_ar[0].size, 4);
                check($sformatf("%s.tbl_arl_addr", vecs[t].name), obs_ar[$].addr,
                      vecs[t].arl_addr);
                check($sformatf("%s.tbl_arl_len", vecs[t].name), obs_ar[$].len,
                      vecs[t].arl_len);
                check($sformatf("%s.tbl_beat0_addr", vecs[t].name), obs_beat[0].addr,
                      vecs[t].beat0_addr);
                check($sformatf("%s.tbl_beat0_head", vecs[t].name), obs_beat[0].head, 1);
                check($sformatf("%s.tbl_last_final", vecs[t].name), obs_beat[$].fin, 1);
                check($sformatf("%s.tbl_last_lbn", vecs[t].name), obs_beat[$].lbn,
                      vecs[t].last_lbn);
            end
        end

        // Zero-length request is accepted and dropped
        clear_all();
        p_addr      = 64'h40;
        p_len       = 0;
        req_pending = 1'b1;
        repeat (4) step(1'b1, 1'b1);
        check("zero.req_taken", 64'(req_pending), 0);
        check("zero.busy", 64'(busy_o), 0);
        check("zero.req_ready", 64'(req_ready_o), 1);
        check("zero.n_ar", obs_ar.size(), 0);

        // Backpressure: four descriptors fill the queue, the fifth AR waits for a pop
        clear_all();
        build_model(64'h0, 64'(6 * 16 * 32));
        p_addr      = 64'h0;
        p_len       = 6 * 16 * 32;
        req_pending = 1'b1;
        repeat (30) step(1'b1, 1'b0);
        check("bp.n_ar_full", obs_ar.size(), 4);
        check("bp.ar_valid_full", 64'(ar_valid_o), 0);
        check("bp.head_rmn", 64'(txn_rmn_beat_o), 15);
        check("bp.head_flag", 64'(txn_is_head_o), 1);
        repeat (16) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("bp.ar_valid_resume", 64'(ar_valid_o), 1);
        drain(100, 100, "bp");

        // New request accepted while the previous one still drains
        clear_all();
        build_model(64'h0, 64'd96);
        build_model(64'h41, 64'd70);
        p_addr      = 64'h0;
        p_len       = 96;
        req_pending = 1'b1;
        for (int i = 0; i < 10 && obs_ar.size() < 1; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("ovl.req_ready", 64'(req_ready_o), 1);
        check("ovl.busy", 64'(busy_o), 1);
        p_addr      = 64'h41;
        p_len       = 70;
        req_pending = 1'b1;
        drain(100, 60, "ovl");

        // Randomized requests, some straddling 4KB pages, with random AR/R backpressure
        for (int r = 0; r < 25; r++) begin
            longint unsigned ra;
            int unsigned     rl;
            if (r % 3 == 0) begin
                ra = 64'(8192 * $urandom_range(1, 8)) - 64'($urandom_range(0, 300));
            end else begin
                ra = 64'($urandom_range(0, 65535));
            end
            rl = $urandom_range(1, 1200);
            clear_all();
            build_model(ra, 64'(rl));
            p_addr      = ra;
            p_len       = rl;
            req_pending = 1'b1;
            drain($urandom_range(30, 100), $urandom_range(30, 100), $sformatf("rnd%0d", r));
        end

        // Maximum length, then reset after two ARs
        clear_all();
        p_addr      = 64'h0;
        p_len       = 32'hFFFF_FFFF;
        req_pending = 1'b1;
        for (int i = 0; i < 20 && obs_ar.size() < 2; i++) step(1'b1, 1'b0);
        check("rstmid.n_ar", obs_ar.size(), 2);
        check("rstmid.head_final", 64'(txn_is_final_txn_o), 0);
        if (obs_ar.size() > 0) begin
            check("rstmid.ar0_len", obs_ar[0].len, 15);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        check("rstmid.ar_valid", 64'(ar_valid_o), 0);
        check("rstmid.txn_valid", 64'(txn_valid_o), 0);
        check("rstmid.req_ready", 64'(req_ready_o), 1);
        check("rstmid.busy", 64'(busy_o), 0);
        hold_ar = 1'b0;
        rst_ni  = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        check("rstmid.after_busy", 64'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
